quad_encoder_rpm: RTL and testbench

//  Parametrised quadrature encoder front end for the motor channel. Samples raw

---
 rtl/quad_encoder_rpm_if.sv | 26 ++
 rtl/quad_encoder_rpm.sv | 139 +++++++++++++
 tb/tb_quad_encoder_rpm.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_encoder_rpm_if.sv
// Pin-side and result-side signals of the quadrature encoder speed front end.
interface quad_encoder_rpm_if #(
    parameter int unsigned GR_W  = 8,
    parameter int unsigned RPM_W = 8,
    parameter int unsigned POS_W = 16
);
    logic             enc_a;
    logic             enc_b;
    logic [GR_W-1:0]  gr;
    logic             err_clr;
    logic [RPM_W-1:0] rpm;
    logic             rpm_dir;
    logic             rpm_valid;
    logic [POS_W-1:0] pos;
    logic             err;

    modport master (
        output enc_a, enc_b, gr, err_clr,
        input  rpm, rpm_dir, rpm_valid, pos, err
    );

    modport slave (
        input  enc_a, enc_b, gr, err_clr,
        output rpm, rpm_dir, rpm_valid, pos, err
    );
endinterface

// File: rtl/quad_encoder_rpm.sv
// x4 quadrature decoder with gated-window speed measurement, gear-ratio scaling,
// free-running position and sticky illegal-transition flag.
module quad_encoder_rpm #(
    parameter int unsigned GATE_CYCLES = 10_000_000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned GR_W        = 8,
    parameter int unsigned GR_SHIFT    = 3,
    parameter int unsigned RPM_W       = 8,
    parameter int unsigned POS_W       = 16
) (
    input  logic               cclk,
    input  logic               rstb,
    quad_encoder_rpm_if.slave  bus
);

    localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned PROD_W = CNT_W + GR_W;
    localparam logic signed [CNT_W:0]  ACC_LIM  = $signed({2'b00, {(CNT_W-1){1'b1}}});
    localparam logic signed [CNT_W:0]  ACC_NLIM = -ACC_LIM;
    localparam logic [PROD_W-1:0]      RPM_MAX  = PROD_W'({RPM_W{1'b1}});

    logic                     a_s1, a_s2, b_s1, b_s2;
    logic [1:0]               ab_prev;
    logic [1:0]               ab_cur_c;
    logic [1:0]               arm_cnt;
    logic                     armed_c;
    logic                     fwd_c, rev_c, illegal_c;
    logic signed [CNT_W:0]    delta_c;
    logic signed [CNT_W:0]    acc_sum_c;
    logic signed [CNT_W-1:0]  acc, acc_next_c, acc_lat;
    logic [GR_W-1:0]          gr_lat;
    logic [GATE_W-1:0]        gate_cnt;
    logic                     win_end_c;
    logic                     lat_vld;
    logic [CNT_W-1:0]         lat_mag_c;
    logic [PROD_W-1:0]        prod_c, prod_shr_c;
    logic [RPM_W-1:0]         rpm_sat_c;

    assign ab_cur_c  = {a_s2, b_s2};
    assign armed_c   = (arm_cnt == 2'd3);
    assign win_end_c = (gate_cnt == GATE_W'(GATE_CYCLES - 1));

    // Gray-sequence decode of {A,B}: 00->10->11->01->00 is forward
    always_comb begin
        fwd_c     = 1'b0;
        rev_c     = 1'b0;
        illegal_c = 1'b0;
        if (armed_c) begin
            case ({ab_prev, ab_cur_c})
                4'b0010, 4'b1011, 4'b1101, 4'b0100: fwd_c     = 1'b1;
                4'b0001, 4'b0111, 4'b1110, 4'b1000: rev_c     = 1'b1;
                4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal_c = 1'b1;
                default: ;
            endcase
        end
    end

    // Symmetric clamp keeps |acc| representable so the magnitude never overflows
    always_comb begin
        delta_c = '0;
        if (fwd_c)      delta_c = (CNT_W+1)'(1);
        else if (rev_c) delta_c = '1;
        acc_sum_c = $signed({acc[CNT_W-1], acc}) + delta_c;
        if (acc_sum_c > ACC_LIM)       acc_next_c = ACC_LIM[CNT_W-1:0];
        else if (acc_sum_c < ACC_NLIM) acc_next_c = ACC_NLIM[CNT_W-1:0];
        else                           acc_next_c = acc_sum_c[CNT_W-1:0];
    end

    // Scale the latched window count and clamp to the output width
    always_comb begin
        lat_mag_c  = acc_lat[CNT_W-1] ? CNT_W'(-acc_lat) : CNT_W'(acc_lat);
        prod_c     = PROD_W'(lat_mag_c) * PROD_W'(gr_lat);
        prod_shr_c = prod_c >> GR_SHIFT;
        rpm_sat_c  = (prod_shr_c > RPM_MAX) ? '1 : prod_shr_c[RPM_W-1:0];
    end

    // Synchroniser, arming delay and previous-state register
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            a_s1    <= 1'b0;
            a_s2    <= 1'b0;
            b_s1    <= 1'b0;
            b_s2    <= 1'b0;
            ab_prev <= 2'b00;
            arm_cnt <= 2'd0;
        end else begin
            a_s1    <= bus.enc_a;
            a_s2    <= a_s1;
            b_s1    <= bus.enc_b;
            b_s2    <= b_s1;
            ab_prev <= ab_cur_c;
            if (!armed_c) arm_cnt <= arm_cnt + 2'd1;
        end
    end

    // Gate window, accumulator and two-stage result pipeline
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            gate_cnt      <= '0;
            acc           <= '0;
            acc_lat       <= '0;
            gr_lat        <= '0;
            lat_vld       <= 1'b0;
            bus.rpm       <= '0;
            bus.rpm_dir   <= 1'b0;
            bus.rpm_valid <= 1'b0;
        end else begin
            if (win_end_c) begin
                gate_cnt <= '0;
                acc      <= '0;
                acc_lat  <= acc_next_c;
                gr_lat   <= bus.gr;
            end else begin
                gate_cnt <= gate_cnt + GATE_W'(1);
                acc      <= acc_next_c;
            end
            lat_vld       <= win_end_c;
            bus.rpm_valid <= lat_vld;
            if (lat_vld) begin
                bus.rpm     <= rpm_sat_c;
                bus.rpm_dir <= acc_lat[CNT_W-1];
            end
        end
    end

    // Wrapping position and sticky error; clear wins over a simultaneous error
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            bus.pos <= '0;
            bus.err <= 1'b0;
        end else begin
            if (fwd_c)      bus.pos <= bus.pos + POS_W'(1);
            else if (rev_c) bus.pos <= bus.pos - POS_W'(1);
            if (bus.err_clr)    bus.err <= 1'b0;
            else if (illegal_c) bus.err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_quad_encoder_rpm.sv
// Directed bench for quad_encoder_rpm: short-window instance plus a long-window
// instance for the accumulator clamp scenario.
module tb_quad_encoder_rpm;

    localparam int unsigned GATE      = 100;
    localparam int unsigned LONG_GATE = 300;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned GR_W      = 8;
    localparam int unsigned GR_SHIFT  = 3;
    localparam int unsigned RPM_W     = 8;
    localparam int unsigned POS_W     = 8;

    logic cclk = 1'b0;
    logic rstb = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic [1:0] ab = 2'b00;

    always #5 cclk = ~cclk;

    quad_encoder_rpm_if #(.GR_W(GR_W), .RPM_W(RPM_W), .POS_W(POS_W)) bus ();
    quad_encoder_rpm_if #(.GR_W(GR_W), .RPM_W(RPM_W), .POS_W(POS_W)) bus_l ();

    assign bus_l.enc_a   = bus.enc_a;
    assign bus_l.enc_b   = bus.enc_b;
    assign bus_l.gr      = bus.gr;
    assign bus_l.err_clr = bus.err_clr;

    quad_encoder_rpm #(
        .GATE_CYCLES(GATE), .CNT_W(CNT_W), .GR_W(GR_W),
        .GR_SHIFT(GR_SHIFT), .RPM_W(RPM_W), .POS_W(POS_W)
    ) u_dut (
        .cclk (cclk),
        .rstb (rstb),
        .bus  (bus)
    );

    quad_encoder_rpm #(
        .GATE_CYCLES(LONG_GATE), .CNT_W(CNT_W), .GR_W(GR_W),
        .GR_SHIFT(GR_SHIFT), .RPM_W(RPM_W), .POS_W(POS_W)
    ) u_dut_long (
        .cclk (cclk),
        .rstb (rstb),
        .bus  (bus_l)
    );

    // cyc = number of rising edges since the last reset release; tasks sit at negedges
    task automatic step(input int n);
        repeat (n) begin
            @(negedge cclk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        @(negedge cclk);
        @(negedge cclk);
        rstb = 1'b1;
        cyc  = 0;
    endtask

    task automatic set_ab(input logic [1:0] v);
        ab        = v;
        bus.enc_a = v[1];
        bus.enc_b = v[0];
    endtask

    function automatic logic [1:0] next_ab(input logic [1:0] cur, input bit fwd);
        logic [1:0] nxt;
        if (fwd) begin
            case (cur)
                2'b00: nxt = 2'b10;
                2'b10: nxt = 2'b11;
                2'b11: nxt = 2'b01;
                default: nxt = 2'b00;
            endcase
        end else begin
            case (cur)
                2'b00: nxt = 2'b01;
                2'b01: nxt = 2'b11;
                2'b11: nxt = 2'b10;
                default: nxt = 2'b00;
            endcase
        end
        return nxt;
    endfunction

    // One legal edge per cycle
    task automatic drive_edges(input int n, input bit fwd);
        for (int i = 0; i < n; i++) begin
            set_ab(next_ab(ab, fwd));
            step(1);
        end
    endtask

    task automatic wait_valid(input bit use_long, input int limit, output int at);
        at = -1;
        while (cyc < limit) begin
            step(1);
            if ((use_long ? bus_l.rpm_valid : bus.rpm_valid) === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int at;
        set_ab(2'b11);
        bus.gr = 8'd8;
        do_reset();
        step(5);
        n_checks++; if (bus.err !== 1'b0)       begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        n_checks++; if (bus.pos !== 8'h00)      begin n_fail++; $display("FAIL reset_pos: got %h expected 00", bus.pos); end
        n_checks++; if (bus.rpm !== 8'h00)      begin n_fail++; $display("FAIL reset_rpm: got %h expected 00", bus.rpm); end
        n_checks++; if (bus.rpm_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.rpm_valid); end
        wait_valid(1'b0, 200, at);
        n_checks++; if (at !== 101)             begin n_fail++; $display("FAIL reset_first_valid_cycle: got %0d expected 101", at); end
        n_checks++; if (bus.rpm !== 8'h00)      begin n_fail++; $display("FAIL reset_idle_rpm: got %h expected 00", bus.rpm); end
        n_checks++; if (bus.rpm_dir !== 1'b0)   begin n_fail++; $display("FAIL reset_idle_dir: got %b expected 0", bus.rpm_dir); end
        n_checks++; if (bus.err !== 1'b0)       begin n_fail++; $display("FAIL reset_armed_err: got %b expected 0", bus.err); end
    endtask

    task automatic test_forward();
        int at;
        set_ab(2'b00);
        bus.gr = 8'd8;
        do_reset();
        step(4);
        drive_edges(40, 1'b1);
        wait_valid(1'b0, 200, at);
        n_checks++; if (at !== 101)           begin n_fail++; $display("FAIL fwd_valid_cycle: got %0d expected 101", at); end
        n_checks++; if (bus.rpm !== 8'd40)    begin n_fail++; $display("FAIL fwd_rpm: got %0d expected 40", bus.rpm); end
        n_checks++; if (bus.rpm_dir !== 1'b0) begin n_fail++; $display("FAIL fwd_dir: got %b expected 0", bus.rpm_dir); end
        n_checks++; if (bus.pos !== 8'd40)    begin n_fail++; $display("FAIL fwd_pos: got %0d expected 40", bus.pos); end
        step(1);
        n_checks++; if (bus.rpm_valid !== 1'b0) begin n_fail++; $display("FAIL fwd_valid_pulse: got %b expected 0", bus.rpm_valid); end
        n_checks++; if (bus.rpm !== 8'd40)      begin n_fail++; $display("FAIL fwd_rpm_hold: got %0d expected 40", bus.rpm); end
    endtask

    task automatic test_reverse();
        int at;
        set_ab(2'b00);
        bus.gr = 8'd24;
        do_reset();
        step(4);
        drive_edges(20, 1'b0);
        wait_valid(1'b0, 200, at);
        n_checks++; if (at !== 101)           begin n_fail++; $display("FAIL rev_valid_cycle: got %0d expected 101", at); end
        n_checks++; if (bus.rpm !== 8'd60)    begin n_fail++; $display("FAIL rev_rpm: got %0d expected 60", bus.rpm); end
        n_checks++; if (bus.rpm_dir !== 1'b1) begin n_fail++; $display("FAIL rev_dir: got %b expected 1", bus.rpm_dir); end
        n_checks++; if (bus.pos !== 8'hEC)    begin n_fail++; $display("FAIL rev_pos: got %h expected ec", bus.pos); end
    endtask

    task automatic test_saturation();
        int at;
        set_ab(2'b00);
        bus.gr = 8'd8;
        do_reset();
        step(4);
        drive_edges(200, 1'b1);
        wait_valid(1'b1, 400, at);
        n_checks++; if (at !== 301)             begin n_fail++; $display("FAIL sat_valid_cycle: got %0d expected 301", at); end
        n_checks++; if (bus_l.rpm !== 8'd127)   begin n_fail++; $display("FAIL sat_acc_clamp_pos: got %0d expected 127", bus_l.rpm); end
        n_checks++; if (bus_l.rpm_dir !== 1'b0) begin n_fail++; $display("FAIL sat_dir_fwd: got %b expected 0", bus_l.rpm_dir); end
        n_checks++; if (bus_l.pos !== 8'hC8)    begin n_fail++; $display("FAIL sat_pos_fwd: got %h expected c8", bus_l.pos); end
        bus.gr = 8'd255;
        drive_edges(200, 1'b0);
        wait_valid(1'b1, 700, at);
        n_checks++; if (at !== 601)             begin n_fail++; $display("FAIL sat_valid_cycle2: got %0d expected 601", at); end
        n_checks++; if (bus_l.rpm !== 8'd255)   begin n_fail++; $display("FAIL sat_rpm_clamp: got %0d expected 255", bus_l.rpm); end
        n_checks++; if (bus_l.rpm_dir !== 1'b1) begin n_fail++; $display("FAIL sat_dir_rev: got %b expected 1", bus_l.rpm_dir); end
        n_checks++; if (bus_l.pos !== 8'h00)    begin n_fail++; $display("FAIL sat_pos_wrap: got %h expected 00", bus_l.pos); end
    endtask

    task automatic test_error();
        set_ab(2'b00);
        bus.err_clr = 1'b0;
        do_reset();
        step(4);
        set_ab(2'b11);
        step(4);
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", bus.err); end
        n_checks++; if (bus.pos !== 8'h00) begin n_fail++; $display("FAIL err_no_count: got %h expected 00", bus.pos); end
        bus.err_clr = 1'b1;
        step(1);
        bus.err_clr = 1'b0;
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", bus.err); end
        // Second illegal jump reaches the decoder two cycles later, together with err_clr
        set_ab(2'b00);
        step(2);
        bus.err_clr = 1'b1;
        step(1);
        bus.err_clr = 1'b0;
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_clr_priority: got %b expected 0", bus.err); end
        step(2);
        n_checks++; if (bus.err !== 1'b0)  begin n_fail++; $display("FAIL err_stays_clear: got %b expected 0", bus.err); end
        n_checks++; if (bus.pos !== 8'h00) begin n_fail++; $display("FAIL err_pos_unchanged: got %h expected 00", bus.pos); end
    endtask

    task automatic test_back_to_back();
        int at;
        set_ab(2'b00);
        bus.gr = 8'd8;
        do_reset();
        step(4);
        drive_edges(4, 1'b1);
        step(97 - cyc);
        // Input change at cycle 97 is decoded on the window-end cycle 99
        drive_edges(1, 1'b1);
        wait_valid(1'b0, 200, at);
        n_checks++; if (at !== 101)        begin n_fail++; $display("FAIL b2b_valid1_cycle: got %0d expected 101", at); end
        n_checks++; if (bus.rpm !== 8'd5)  begin n_fail++; $display("FAIL b2b_edge_at_end: got %0d expected 5", bus.rpm); end
        n_checks++; if (bus.pos !== 8'd5)  begin n_fail++; $display("FAIL b2b_pos: got %0d expected 5", bus.pos); end
        wait_valid(1'b0, 300, at);
        n_checks++; if (at !== 201)           begin n_fail++; $display("FAIL b2b_valid2_cycle: got %0d expected 201", at); end
        n_checks++; if (bus.rpm !== 8'd0)     begin n_fail++; $display("FAIL b2b_next_window_rpm: got %0d expected 0", bus.rpm); end
        n_checks++; if (bus.rpm_dir !== 1'b0) begin n_fail++; $display("FAIL b2b_zero_dir: got %b expected 0", bus.rpm_dir); end
    endtask

    task automatic test_midwindow_reset();
        int at;
        set_ab(2'b00);
        bus.gr = 8'd8;
        do_reset();
        step(4);
        drive_edges(8, 1'b1);
        step(50 - cyc);
        do_reset();
        n_checks++; if (bus.pos !== 8'h00) begin n_fail++; $display("FAIL mid_pos_cleared: got %h expected 00", bus.pos); end
        wait_valid(1'b0, 150, at);
        n_checks++; if (at !== 101)        begin n_fail++; $display("FAIL mid_valid_cycle: got %0d expected 101", at); end
        n_checks++; if (bus.rpm !== 8'd0)  begin n_fail++; $display("FAIL mid_partial_discarded: got %0d expected 0", bus.rpm); end
    endtask

    task automatic test_pipeline_kill();
        int at;
        set_ab(2'b00);
        bus.gr = 8'd8;
        do_reset();
        step(4);
        drive_edges(8, 1'b1);
        step(100 - cyc);
        // Window result is latched and one cycle from rpm_valid
        do_reset();
        n_checks++; if (bus.rpm_valid !== 1'b0) begin n_fail++; $display("FAIL kill_valid: got %b expected 0", bus.rpm_valid); end
        n_checks++; if (bus.rpm !== 8'd0)       begin n_fail++; $display("FAIL kill_rpm: got %0d expected 0", bus.rpm); end
        wait_valid(1'b0, 150, at);
        n_checks++; if (at !== 101)             begin n_fail++; $display("FAIL kill_valid_cycle: got %0d expected 101", at); end
        n_checks++; if (bus.rpm !== 8'd0)       begin n_fail++; $display("FAIL kill_new_rpm: got %0d expected 0", bus.rpm); end
    endtask

    initial begin
        bus.enc_a   = 1'b0;
        bus.enc_b   = 1'b0;
        bus.gr      = '0;
        bus.err_clr = 1'b0;
        test_reset();
        test_forward();
        test_reverse();
        test_saturation();
        test_error();
        test_back_to_back();
        test_midwindow_reset();
        test_pipeline_kill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
